gmux_switch_ctrl: RTL and testbench

- Synchronous sequencer for one GMUX global-clock mux.
- Performs a glitch-safe source switch between GCLKIN (ssel=0) and GHSCK (ssel=1): gate off all four quadrant enables, wait a guard time, flip SSEL, wait a settle time, then apply a new quadrant enable/low-power configuration.
- Sits in the clock-management fabric between a configuration/requester port and the GMUX control pins (SSEL, {TL,TR,BL,BR}_{SEN,DEN,DYNEN,VLP}).

---
 rtl/gmux_ctrl_pkg.sv | 47 ++++
 rtl/gmux_ctrl_timer.sv | 27 ++
 rtl/gmux_switch_ctrl.sv | 165 ++++++++++++++++
 tb/tb_gmux_switch_ctrl.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/gmux_ctrl_pkg.sv
// Shared types and constants for the GMUX source-switch sequencer.
// Holds the FSM state encoding, quadrant/source constants and the APPLY-edge helper.
package gmux_ctrl_pkg;

    localparam int NQ  = 4;
    localparam int QTL = 0;
    localparam int QTR = 1;
    localparam int QBL = 2;
    localparam int QBR = 3;

    localparam logic SRC_GCLKIN = 1'b0;
    localparam logic SRC_HSCK   = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        DRAIN,
        SWITCH,
        SETTLE,
        APPLY
    } state_t;

    typedef struct packed {
        logic          sel;
        logic [NQ-1:0] qmask;
        logic [NQ-1:0] vlp;
    } sw_req_t;

    typedef struct packed {
        logic [NQ-1:0] sen;
        logic [NQ-1:0] den;
        logic [NQ-1:0] dynen;
        logic [NQ-1:0] vlp;
    } qcfg_t;

    localparam qcfg_t CFG_RESET = '{sen: 4'h0, den: 4'h0, dynen: 4'h0, vlp: 4'hF};

    // A quadrant asking for VLP keeps its static enable but loses the dynamic ones.
    function automatic qcfg_t apply_cfg(input logic [NQ-1:0] qmask, input logic [NQ-1:0] vlp_req);
        qcfg_t cfg;
        cfg.sen   = qmask;
        cfg.den   = qmask & ~vlp_req;
        cfg.dynen = qmask & ~vlp_req;
        cfg.vlp   = ~qmask | vlp_req;
        return cfg;
    endfunction

endpackage

// File: rtl/gmux_ctrl_timer.sv
// Loadable down-counter with a zero flag; times the guard and settle windows.
module gmux_ctrl_timer #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_value,
    input  logic             i_dec,
    output logic             o_zero
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_value;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/gmux_switch_ctrl.sv
// Glitch-safe GMUX source switch: drain all quadrant enables, flip SSEL, settle,
// then apply the requested quadrant enable / very-low-power configuration.
module gmux_switch_ctrl
    import gmux_ctrl_pkg::*;
#(
    parameter int GUARD_CYCLES  = 4,
    parameter int SETTLE_CYCLES = 8,
    parameter int CNT_W         = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_sel,
    input  logic [NQ-1:0] req_qmask,
    input  logic [NQ-1:0] req_vlp,
    output logic          ssel,
    output logic [NQ-1:0] sen,
    output logic [NQ-1:0] den,
    output logic [NQ-1:0] dynen,
    output logic [NQ-1:0] vlp,
    output logic          busy,
    output logic          done
);

    localparam int MAX_WAIT = (GUARD_CYCLES > SETTLE_CYCLES) ? GUARD_CYCLES : SETTLE_CYCLES;

    if (GUARD_CYCLES < 1) begin : g_bad_guard
        $error("gmux_switch_ctrl: GUARD_CYCLES must be >= 1");
    end
    if (SETTLE_CYCLES < 1) begin : g_bad_settle
        $error("gmux_switch_ctrl: SETTLE_CYCLES must be >= 1");
    end
    if (MAX_WAIT > (2 ** CNT_W) - 1) begin : g_bad_cnt_w
        $error("gmux_switch_ctrl: CNT_W too narrow for GUARD_CYCLES/SETTLE_CYCLES");
    end

    localparam logic [CNT_W-1:0] GUARD_LOAD  = CNT_W'(GUARD_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

    state_t  r_state;
    logic    r_ssel;
    qcfg_t   r_cfg;
    logic    r_done;
    sw_req_t r_req;

    state_t           w_state_nxt;
    logic             w_ssel_nxt;
    qcfg_t            w_cfg_nxt;
    logic             w_done_nxt;
    logic             w_latch;
    logic             w_tmr_load;
    logic [CNT_W-1:0] w_tmr_value;
    logic             w_tmr_dec;
    logic             w_tmr_zero;
    sw_req_t          w_req_in;
    sw_req_t          w_apply_src;

    assign w_req_in = '{sel: req_sel, qmask: req_qmask, vlp: req_vlp};

    // A same-source request applies on its accept edge, before r_req holds it.
    assign w_apply_src = (r_state == IDLE) ? w_req_in : r_req;

    gmux_ctrl_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_tmr_load),
        .i_value (w_tmr_value),
        .i_dec   (w_tmr_dec),
        .o_zero  (w_tmr_zero)
    );

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path infers a latch.
        w_state_nxt = r_state;
        w_ssel_nxt  = r_ssel;
        w_cfg_nxt   = r_cfg;
        w_done_nxt  = 1'b0;
        w_latch     = 1'b0;
        w_tmr_load  = 1'b0;
        w_tmr_value = '0;
        w_tmr_dec   = 1'b0;

        case (r_state)
            IDLE: begin
                if (req_valid) begin
                    w_latch = 1'b1;
                    if (req_sel != r_ssel) begin
                        w_state_nxt     = DRAIN;
                        w_cfg_nxt.sen   = '0;
                        w_cfg_nxt.den   = '0;
                        w_cfg_nxt.dynen = '0;
                        w_tmr_load      = 1'b1;
                        w_tmr_value     = GUARD_LOAD;
                    end else begin
                        w_state_nxt = APPLY;
                    end
                end
            end
            DRAIN: begin
                if (w_tmr_zero) begin
                    w_state_nxt = SWITCH;
                    w_ssel_nxt  = r_req.sel;
                    w_tmr_load  = 1'b1;
                    w_tmr_value = SETTLE_LOAD;
                end else begin
                    w_tmr_dec = 1'b1;
                end
            end
            // The SWITCH cycle is the first settle cycle, so a 1-cycle settle skips SETTLE.
            SWITCH, SETTLE: begin
                if (w_tmr_zero) begin
                    w_state_nxt = APPLY;
                end else begin
                    w_state_nxt = SETTLE;
                    w_tmr_dec   = 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        // APPLY is taken on a single edge; the register lands back in IDLE with done.
        if (w_state_nxt == APPLY) begin
            w_cfg_nxt   = apply_cfg(w_apply_src.qmask, w_apply_src.vlp);
            w_done_nxt  = 1'b1;
            w_state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            r_state <= IDLE;
            r_ssel  <= SRC_GCLKIN;
            r_cfg   <= CFG_RESET;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ssel  <= w_ssel_nxt;
            r_cfg   <= w_cfg_nxt;
            r_done  <= w_done_nxt;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: the request holding register is always written before it is read, so it has no reset.
        if (w_latch) begin
            r_req <= w_req_in;
        end
    end

    assign req_ready = (r_state == IDLE);
    assign busy      = (r_state != IDLE);
    assign ssel      = r_ssel;
    assign sen       = r_cfg.sen;
    assign den       = r_cfg.den;
    assign dynen     = r_cfg.dynen;
    assign vlp       = r_cfg.vlp;
    assign done      = r_done;

endmodule

// File: tb/tb_gmux_switch_ctrl.sv
// Directed bench for gmux_switch_ctrl: default timing plus a GUARD=SETTLE=1 instance,
// with a negedge monitor for the guard/settle/switch-state invariants.
module tb_gmux_switch_ctrl;
    import gmux_ctrl_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       req_valid, req_sel;
    logic [3:0] req_qmask, req_vlp;
    logic       req_ready, ssel, busy, done;
    logic [3:0] sen, den, dynen, vlp;

    logic       f_req_valid, f_req_sel;
    logic [3:0] f_req_qmask, f_req_vlp;
    logic       f_req_ready, f_ssel, f_busy, f_done;
    logic [3:0] f_sen, f_den, f_dynen, f_vlp;

    int checks   = 0;
    int failures = 0;

    gmux_switch_ctrl dut (
        .clk (clk), .rst (rst),
        .req_valid (req_valid), .req_ready (req_ready), .req_sel (req_sel),
        .req_qmask (req_qmask), .req_vlp (req_vlp),
        .ssel (ssel), .sen (sen), .den (den), .dynen (dynen), .vlp (vlp),
        .busy (busy), .done (done)
    );

    gmux_switch_ctrl #(.GUARD_CYCLES(1), .SETTLE_CYCLES(1), .CNT_W(4)) dut_fast (
        .clk (clk), .rst (rst),
        .req_valid (f_req_valid), .req_ready (f_req_ready), .req_sel (f_req_sel),
        .req_qmask (f_req_qmask), .req_vlp (f_req_vlp),
        .ssel (f_ssel), .sen (f_sen), .den (f_den), .dynen (f_dynen), .vlp (f_vlp),
        .busy (f_busy), .done (f_done)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic e_ssel, input logic [3:0] e_sen,
                              input logic [3:0] e_den, input logic [3:0] e_dynen,
                              input logic [3:0] e_vlp, input logic e_ready,
                              input logic e_busy, input logic e_done);
        check({tag, ".ssel"},  8'(ssel),      8'(e_ssel));
        check({tag, ".sen"},   8'(sen),       8'(e_sen));
        check({tag, ".den"},   8'(den),       8'(e_den));
        check({tag, ".dynen"}, 8'(dynen),     8'(e_dynen));
        check({tag, ".vlp"},   8'(vlp),       8'(e_vlp));
        check({tag, ".ready"}, 8'(req_ready), 8'(e_ready));
        check({tag, ".busy"},  8'(busy),      8'(e_busy));
        check({tag, ".done"},  8'(done),      8'(e_done));
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Invariant monitor on the default instance; cycles right after a sampled reset are skipped.
    logic       rst_seen  = 1'b1;
    logic       prev_ssel = 1'b0;
    logic [3:0] prev_en   = 4'h0;
    int         zero_run  = 0;
    int         since_sw  = 1000;
    int         n_sw      = 0;

    always @(posedge clk) rst_seen <= rst;

    always @(negedge clk) begin
        logic [3:0] en;
        en = sen | den | dynen;
        if (!rst_seen) begin
            if (ssel !== prev_ssel) begin
                n_sw++;
                check("inv.guard", 8'(zero_run >= 4), 8'd1);
                check("inv.ssel_in_switch", 8'(dut.r_state == SWITCH), 8'd1);
                since_sw = 0;
            end else if (since_sw < 1000) begin
                since_sw++;
            end
            if ((en & ~prev_en) != 4'h0) begin
                check("inv.settle", 8'(since_sw >= 8), 8'd1);
            end
        end
        zero_run  = (en == 4'h0) ? zero_run + 1 : 0;
        prev_ssel = ssel;
        prev_en   = en;
    end

    logic [3:0] q_tab    [4] = '{4'h9, 4'h6, 4'hC, 4'h3};
    logic [3:0] vout_tab [4] = '{4'h6, 4'h9, 4'h3, 4'hC};

    initial begin
        logic exp_sel;
        rst = 1'b1;
        req_valid = 1'b0; req_sel = 1'b0; req_qmask = 4'h0; req_vlp = 4'h0;
        f_req_valid = 1'b0; f_req_sel = 1'b0; f_req_qmask = 4'h0; f_req_vlp = 4'h0;
        cyc(3);
        rst = 1'b0;

        for (int i = 0; i < 5; i++) begin
            cyc(1);
            check_outs("reset_idle", 1'b0, 4'h0, 4'h0, 4'h0, 4'hF, 1'b1, 1'b0, 1'b0);
        end

        // GUARD=SETTLE=1: ssel flips in cycle 2, done in cycle 3.
        f_req_valid = 1'b1; f_req_sel = 1'b1; f_req_qmask = 4'hA; f_req_vlp = 4'h2;
        cyc(1);
        f_req_valid = 1'b0;
        check("fast.c1.ssel", 8'(f_ssel), 8'd0);
        check("fast.c1.busy", 8'(f_busy), 8'd1);
        cyc(1);
        check("fast.c2.ssel", 8'(f_ssel), 8'd1);
        check("fast.c2.sen",  8'(f_sen),  8'h0);
        check("fast.c2.done", 8'(f_done), 8'd0);
        cyc(1);
        check("fast.c3.done",  8'(f_done),      8'd1);
        check("fast.c3.sen",   8'(f_sen),       8'hA);
        check("fast.c3.den",   8'(f_den),       8'h8);
        check("fast.c3.dynen", 8'(f_dynen),     8'h8);
        check("fast.c3.vlp",   8'(f_vlp),       8'h7);
        check("fast.c3.ready", 8'(f_req_ready), 8'd1);
        cyc(1);
        check("fast.c4.done", 8'(f_done), 8'd0);

        // Source change 0->1; busy-time input changes must be ignored.
        req_valid = 1'b1; req_sel = 1'b1; req_qmask = 4'hF; req_vlp = 4'h0;
        for (int c = 1; c <= 12; c++) begin
            cyc(1);
            check_outs("sw1.busy", (c >= 5), 4'h0, 4'h0, 4'h0, 4'hF, 1'b0, 1'b1, 1'b0);
            if (c == 1) req_valid = 1'b0;
            if (c == 3) begin
                req_valid = 1'b1; req_sel = 1'b0; req_qmask = 4'h0; req_vlp = 4'hF;
            end
            if (c == 6) begin
                req_valid = 1'b0; req_sel = 1'b1; req_qmask = 4'hF; req_vlp = 4'h0;
            end
        end
        cyc(1);
        check_outs("sw1.done", 1'b1, 4'hF, 4'hF, 4'hF, 4'h0, 1'b1, 1'b0, 1'b1);
        cyc(1);
        check("sw1.done_pulse", 8'(done), 8'd0);

        // Same source: done one cycle after accept; VLP wins on overlapping bit 0.
        req_valid = 1'b1; req_sel = 1'b1; req_qmask = 4'h5; req_vlp = 4'h1;
        cyc(1);
        req_valid = 1'b0;
        check_outs("same.done", 1'b1, 4'h5, 4'h4, 4'h4, 4'hB, 1'b1, 1'b0, 1'b1);
        cyc(1);
        check("same.done_pulse", 8'(done), 8'd0);

        // Reset in SETTLE (cycle 8 of a 1->0 switch) aborts the sequence.
        req_valid = 1'b1; req_sel = 1'b0; req_qmask = 4'hF; req_vlp = 4'h0;
        for (int c = 1; c <= 8; c++) begin
            cyc(1);
            if (c == 1) req_valid = 1'b0;
        end
        check_outs("abort.c8", 1'b0, 4'h0, 4'h0, 4'h0, 4'hB, 1'b0, 1'b1, 1'b0);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        check_outs("abort.reset", 1'b0, 4'h0, 4'h0, 4'h0, 4'hF, 1'b1, 1'b0, 1'b0);
        cyc(1);
        check_outs("abort.idle", 1'b0, 4'h0, 4'h0, 4'h0, 4'hF, 1'b1, 1'b0, 1'b0);
        req_valid = 1'b1; req_sel = 1'b1; req_qmask = 4'h3; req_vlp = 4'h2;
        for (int c = 1; c <= 12; c++) begin
            cyc(1);
            if (c == 1) req_valid = 1'b0;
        end
        check("post_abort.c12.done", 8'(done), 8'd0);
        cyc(1);
        check_outs("post_abort.done", 1'b1, 4'h3, 4'h1, 4'h1, 4'hE, 1'b1, 1'b0, 1'b1);

        // qmask=0 same source: everything off, vlp all set, done still pulses.
        cyc(1);
        req_valid = 1'b1; req_sel = 1'b1; req_qmask = 4'h0; req_vlp = 4'h0;
        cyc(1);
        req_valid = 1'b0;
        check_outs("qmask0.done", 1'b1, 4'h0, 4'h0, 4'h0, 4'hF, 1'b1, 1'b0, 1'b1);

        // Back-to-back: req_valid held, sel alternates on each accept in the done cycle.
        cyc(1);
        exp_sel = 1'b0;
        req_valid = 1'b1; req_sel = exp_sel; req_qmask = q_tab[0]; req_vlp = 4'h0;
        for (int k = 0; k < 4; k++) begin
            for (int c = 1; c <= 13; c++) begin
                cyc(1);
                if (c == 1) check("b2b.accepted", 8'(req_ready), 8'd0);
                if (c < 13) begin
                    check("b2b.no_done", 8'(done), 8'd0);
                end else begin
                    check("b2b.done",  8'(done),      8'd1);
                    check("b2b.ready", 8'(req_ready), 8'd1);
                    check("b2b.ssel",  8'(ssel),      8'(exp_sel));
                    check("b2b.sen",   8'(sen),       8'(q_tab[k]));
                    check("b2b.den",   8'(den),       8'(q_tab[k]));
                    check("b2b.vlp",   8'(vlp),       8'(vout_tab[k]));
                    if (k < 3) begin
                        exp_sel   = ~exp_sel;
                        req_sel   = exp_sel;
                        req_qmask = q_tab[k+1];
                    end else begin
                        req_valid = 1'b0;
                    end
                end
            end
        end
        cyc(1);
        check("b2b.end.busy", 8'(busy), 8'd0);
        check("b2b.end.done", 8'(done), 8'd0);
        check("mon.switches", 8'(n_sw), 8'd7);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
